// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding, constants and fetch-entry type for the instruction fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} ifu_state_t;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: two-entry FIFO with flush; the head entry is held in its own register
module ifu_fetch_queue
  import ifu_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   push,
  input  logic   pop,
  input  entry_t push_data,
  output entry_t head,
  output logic   valid,
  output logic   full
);
  entry_t tail;
  logic [1:0] cnt;
  assign valid = cnt != 2'd0;
  assign full = cnt == 2'd2;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      head <= (pop && full) ? tail : (push && (!valid || (pop && cnt == 2'd1))) ? push_data : head;
      tail <= (push && ((cnt == 2'd1 && !pop) || (full && pop))) ? push_data : tail;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: PC/FSM front end feeding a 2-entry fetch queue; IFU_PERF_CNT_EN adds perf counters
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_raddr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);
  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;
  ifu_state_t state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic full, pop, push, is_ebreak;
  entry_t head, push_data;
  assign imem_raddr = ADDR_WIDTH'((pc[ADDR_WIDTH+1:0] - RESET_PC[ADDR_WIDTH+1:0]) >> 2);
  assign pop = out_valid && out_ready && !redirect_valid;
  assign push = state == RUN && !redirect_valid && (!full || pop);
  assign is_ebreak = imem_rdata == DATA_WIDTH'(EBREAK_INSTR);
  assign halted = state == HALT;
  assign push_data = '{pc: pc, instr: imem_rdata};
  assign out_pc = head.pc;
  assign out_instr = head.instr;
  always_comb begin
    state_n = (redirect_valid || state == BOOT) ? RUN : (push && is_ebreak) ? HALT : state;
    pc_n = redirect_valid ? (redirect_pc & ~PC_WIDTH'(3)) : (push && !is_ebreak) ? pc + PC_WIDTH'(4) : pc;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= BOOT;
      pc <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
    end
  ifu_fetch_queue #(.entry_t(entry_t)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .head      (head),
    .valid     (out_valid),
    .full      (full)
  );
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      perf_fetch_cnt <= perf_fetch_cnt + 32'(push);
      perf_stall_cnt <= perf_stall_cnt + 32'(state == RUN && full && !pop);
    end
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scoreboard bench; expected stream derived from memory contents in program order
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  logic clk = 0, rst = 1, redirect_valid = 0, out_ready = 0;
  logic [31:0] redirect_pc = 0;
  logic [7:0] imem_raddr;
  logic [31:0] imem_rdata, out_pc, out_instr;
  logic out_valid, halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  ent_t expq[$];
  ent_t me;
  bit halt_exp = 0, hold = 0;
  logic [31:0] ppc, pin;
  assign imem_rdata = mem[imem_raddr];
  always #5 clk = ~clk;
  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_raddr     (imem_raddr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .halted         (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] p);
    logic [31:0] o;
    o = p - RST_PC;
    return mem[o[9:2]];
  endfunction
  function automatic void restart(input logic [31:0] p);
    ent_t e;
    logic [31:0] q;
    q = p & ~32'd3;
    expq.delete();
    halt_exp = 0;
    for (int i = 0; i < 260; i++) begin
      e.pc = q;
      e.instr = word_at(q);
      expq.push_back(e);
      if (e.instr == EBRK) break;
      q = q + 32'd4;
    end
  endfunction
  task automatic do_reset(input logic rdy);
    rst = 1;
    redirect_valid = 0;
    out_ready = rdy;
    restart(RST_PC);
    step(2);
    rst = 0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", {out_pc, out_instr}, {ppc, pin});
      end
      if (halt_exp) begin
        chk("halt_flag", 64'(halted), 64'd1);
        chk("halt_idle", 64'(out_valid), 64'd0);
      end
      if (out_valid && out_ready && !redirect_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got pc %h, expected no output", out_pc);
        end else begin
          me = expq.pop_front();
          chk("out_pc", 64'(out_pc), 64'(me.pc));
          chk("out_instr", 64'(out_instr), 64'(me.instr));
          if (me.instr == EBRK) halt_exp = 1;
        end
      end
      hold = out_valid && !out_ready && !redirect_valid;
      ppc = out_pc;
      pin = out_instr;
    end else hold = 0;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h13;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = EBRK;
    do_reset(1);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_head", {out_pc, out_instr}, 64'd0);
    chk("rst_raddr", 64'(imem_raddr), 64'd0);
    step();
    chk("boot_no_push", 64'(out_valid), 64'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("seq_valid", 64'(out_valid), 64'd1);
      chk("seq_pc", 64'(out_pc), 64'(RST_PC + 32'(4 * i)));
      step();
    end
    chk("halt_after_ebreak", 64'(halted), 64'd1);
    step(3);
    chk("halt_no_push", 64'(out_valid), 64'd0);
`ifdef IFU_PERF_CNT_EN
    do_reset(0);
    step(3);
    chk("perf_fill", 64'(perf_fetch_cnt), 64'd2);
    step(3);
    chk("perf_stall", 64'(perf_stall_cnt), 64'd3);
    out_ready = 1;
    step(6);
    chk("perf_fetch_final", 64'(perf_fetch_cnt), 64'd4);
    chk("perf_stall_final", 64'(perf_stall_cnt), 64'd3);
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 256 + 32'h13);
    mem[200] = EBRK;
    do_reset(0);
    step(5);
    chk("stall_pc", 64'(imem_raddr), 64'd2);
    chk("stall_head", 64'(out_pc), 64'(RST_PC));
    out_ready = 1;
    step(3);
    out_ready = 0;
    step(3);
    redirect_valid = 1;
    redirect_pc = 32'h8000_0043;
    restart(redirect_pc);
    step();
    redirect_valid = 0;
    chk("redir_flush", 64'(out_valid), 64'd0);
    chk("redir_raddr", 64'(imem_raddr), 64'h10);
    step();
    chk("redir_valid", 64'(out_valid), 64'd1);
    chk("redir_pc", 64'(out_pc), 64'h8000_0040);
    out_ready = 1;
    step(4);
    mem[1] = EBRK;
    do_reset(0);
    step(3);
    chk("halt_queued", {63'(halted), out_valid}, 64'd3);
    redirect_valid = 1;
    redirect_pc = RST_PC;
    restart(RST_PC);
    step();
    redirect_valid = 0;
    chk("halt_redir_flush", {63'(halted), out_valid}, 64'd0);
    chk("halt_redir_raddr", 64'(imem_raddr), 64'd0);
    step();
    chk("halt_redir_pc", {63'(out_valid), out_pc}, {31'd0, 1'b1, RST_PC});
    out_ready = 1;
    step(4);
    mem[1] = 32'h113;
    do_reset(0);
    step(4);
    rst = 1;
    redirect_valid = 1;
    redirect_pc = 32'h8000_0100;
    restart(RST_PC);
    step();
    rst = 0;
    redirect_valid = 0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_raddr", 64'(imem_raddr), 64'd0);
    step();
    chk("midrst_boot", 64'(out_valid), 64'd0);
    step();
    chk("midrst_pc", {63'(out_valid), out_pc}, {31'd0, 1'b1, RST_PC});
    out_ready = 1;
    step(2);
    for (int s = 0; s < 20; s++) begin
      rst = 1;
      redirect_valid = 0;
      for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(15) == 0) ? EBRK : $urandom();
      mem[$urandom_range(255)] = EBRK;
      restart(RST_PC);
      step($urandom_range(2, 1));
      rst = 0;
      for (int c = 0; c < 60; c++) begin
        out_ready = $urandom_range(3) != 0;
        redirect_valid = $urandom_range(19) == 0;
        redirect_pc = ($urandom_range(1) == 0) ? $urandom() : RST_PC + 32'($urandom_range(1023));
        rst = $urandom_range(59) == 0;
        if (rst) restart(RST_PC);
        else if (redirect_valid) restart(redirect_pc);
        step();
      end
      rst = 0;
      redirect_valid = 0;
      out_ready = 1;
      for (int c = 0; c < 600 && !halt_exp; c++) step();
      chk("drain_to_halt", 64'(halt_exp), 64'd1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
